lcd_show_string_ctrl: RTL and testbench

Sequencer that renders a string of up to MAX_LEN ASCII characters on the LCD by driving the single-character engine (show_char_flag / ascii_num / start_x / start_y in, show_char_done out) once per character. It owns a small character buffer loaded by the host, converts ASCII to glyph index, advances the cursor, and handles line wrap, newline and bottom-of-screen overflow. It sits between the application logic and the character engine, upstream of the SPI write path.

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_str_buf.sv | 23 ++
 rtl/lcd_show_string_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lcd_show_string_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD constants: font geometry, ASCII mapping, screen defaults and the
// string sequencer state encoding.
package lcd_pkg;

    localparam int SCREEN_W_DEF = 240;
    localparam int SCREEN_H_DEF = 320;
    localparam int MAX_LEN_DEF  = 16;

    localparam logic [9:0] FONT0_W = 10'd6;
    localparam logic [9:0] FONT0_H = 10'd12;
    localparam logic [9:0] FONT1_W = 10'd8;
    localparam logic [9:0] FONT1_H = 10'd16;

    localparam logic [6:0] ASCII_BASE = 7'h20;
    localparam logic [6:0] ASCII_LAST = 7'h7E;
    localparam logic [6:0] NEWLINE    = 7'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } str_state_e;

    function automatic logic [9:0] glyph_w(input logic sz);
        return sz ? FONT1_W : FONT0_W;
    endfunction

    function automatic logic [9:0] glyph_h(input logic sz);
        return sz ? FONT1_H : FONT0_H;
    endfunction

    // Non-printable codes render as a space (glyph 0).
    function automatic logic [6:0] glyph_index(input logic [6:0] code);
        return (code >= ASCII_BASE && code <= ASCII_LAST) ? code - ASCII_BASE : 7'd0;
    endfunction

endpackage

// File: rtl/lcd_str_buf.sv
// Character buffer: DEPTH x 7-bit register file, one write port and one
// registered read port. Contents are intentionally not reset.
module lcd_str_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_data
);

    logic [6:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/lcd_show_string_ctrl.sv
// String sequencer: walks the character buffer and drives the single-character
// engine once per glyph, handling cursor advance, wrap, newline and overflow.
module lcd_show_string_ctrl
    import lcd_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int MAX_LEN  = MAX_LEN_DEF,
    parameter int AW       = $clog2(MAX_LEN)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_addr,
    input  logic [6:0]    buf_data,
    input  logic          str_req,
    input  logic [AW:0]   str_len,
    input  logic [8:0]    str_x,
    input  logic [8:0]    str_y,
    input  logic          size_sel,
    input  logic          show_char_done,
    output logic          show_char_flag,
    output logic [6:0]    ascii_num,
    output logic [8:0]    start_x,
    output logic [8:0]    start_y,
    output logic          en_size,
    output logic          busy,
    output logic          str_done,
    output logic          overflow
);

    localparam logic [9:0] SW      = 10'(SCREEN_W);
    localparam logic [9:0] SH      = 10'(SCREEN_H);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    str_state_e  state;
    logic [AW:0] idx, len, idx_inc;
    logic [9:0]  org_x, cur_x, cur_y;
    logic        size_q, nl_q, prime;
    logic [9:0]  gw, gh, adv_x, nxt_x, nxt_y;
    logic        wrap, ovf;
    logic [AW-1:0] rd_addr;
    logic [6:0]  rd_data;

    assign idx_inc = idx + ONE;
    assign gw      = glyph_w(size_q);
    assign gh      = glyph_h(size_q);

    // In NEXT the read port is pointed at the upcoming index so LOAD sees it
    // without an extra cycle.
    assign rd_addr = (state == S_NEXT) ? idx_inc[AW-1:0] : idx[AW-1:0];

    lcd_str_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .sys_clk (sys_clk),
        .we      (buf_we && !busy),
        .wr_addr (buf_addr),
        .wr_data (buf_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        adv_x = cur_x + gw;
        wrap  = nl_q || (adv_x + gw > SW);
        nxt_x = wrap ? org_x : adv_x;
        nxt_y = wrap ? cur_y + gh : cur_y;
        ovf   = (nxt_y + gh > SH) && (idx_inc < len);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            len            <= '0;
            org_x          <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
            size_q         <= 1'b0;
            nl_q           <= 1'b0;
            prime          <= 1'b0;
            show_char_flag <= 1'b0;
            ascii_num      <= '0;
            start_x        <= '0;
            start_y        <= '0;
            en_size        <= 1'b0;
            busy           <= 1'b0;
            str_done       <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (str_req) begin
                        len     <= (str_len > LEN_MAX) ? LEN_MAX : str_len;
                        size_q  <= size_sel;
                        en_size <= size_sel;
                        org_x   <= {1'b0, str_x};
                        cur_x   <= {1'b0, str_x};
                        cur_y   <= {1'b0, str_y};
                        idx     <= '0;
                        prime   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // First LOAD after a start waits for the registered read of
                    // entry 0; an empty string finishes from here.
                    if (prime) begin
                        prime <= 1'b0;
                        if (len == '0) begin
                            str_done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end else if (rd_data == NEWLINE) begin
                        nl_q  <= 1'b1;
                        state <= S_NEXT;
                    end else begin
                        nl_q           <= 1'b0;
                        ascii_num      <= glyph_index(rd_data);
                        start_x        <= cur_x[8:0];
                        start_y        <= cur_y[8:0];
                        show_char_flag <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    show_char_flag <= 1'b0;
                    state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (show_char_done)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    idx   <= idx_inc;
                    cur_x <= nxt_x;
                    cur_y <= nxt_y;
                    if (ovf) begin
                        overflow <= 1'b1;
                        str_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (idx_inc == len) begin
                        str_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    str_done <= 1'b0;
                    overflow <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_show_string_ctrl.sv
// Randomized bench for lcd_show_string_ctrl with a list-based glyph placement model.
`timescale 1ns/1ps
module tb_lcd_show_string_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       buf_we = 1'b0;
    logic [3:0] buf_addr = '0;
    logic [6:0] buf_data = '0;
    logic       str_req = 1'b0;
    logic [4:0] str_len = '0;
    logic [8:0] str_x = '0;
    logic [8:0] str_y = '0;
    logic       size_sel = 1'b0;
    logic       show_char_done = 1'b0;
    logic       show_char_flag;
    logic [6:0] ascii_num;
    logic [8:0] start_x, start_y;
    logic       en_size, busy, str_done, overflow;

    lcd_show_string_ctrl dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
        .str_req(str_req), .str_len(str_len), .str_x(str_x), .str_y(str_y),
        .size_sel(size_sel), .show_char_done(show_char_done),
        .show_char_flag(show_char_flag), .ascii_num(ascii_num),
        .start_x(start_x), .start_y(start_y), .en_size(en_size),
        .busy(busy), .str_done(str_done), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int a;
        int x;
        int y;
        int idx;
    } glyph_t;

    int     checks = 0;
    int     failures = 0;
    logic [6:0] tb_buf [16];
    glyph_t exp_q[$];
    glyph_t got_q[$];
    bit     exp_ovf, got_ovf;

    // Where each character lands, straight from the placement rules.
    task automatic model_string(input int len, input int x, input int y, input bit sz);
        int cx, cy, w, h, c;
        glyph_t g;
        exp_q.delete();
        exp_ovf = 0;
        cx = x; cy = y;
        w = sz ? 8 : 6;
        h = sz ? 16 : 12;
        for (int i = 0; i < len; i++) begin
            c = int'(tb_buf[i]);
            if (c != 10) begin
                g.a = (c >= 32 && c <= 126) ? c - 32 : 0;
                g.x = cx; g.y = cy; g.idx = i;
                exp_q.push_back(g);
            end
            cx = cx + w;
            if (c == 10 || cx + w > 240) begin
                cx = x;
                cy = cy + h;
            end
            if (cy + h > 320 && i + 1 < len) begin
                exp_ovf = 1;
                break;
            end
        end
    endtask

    task automatic write_buf(input int addr, input int data);
        buf_we = 1'b1;
        buf_addr = 4'(addr);
        buf_data = 7'(data);
        tb_buf[addr] = 7'(data);
        @(posedge sys_clk); #1;
        buf_we = 1'b0;
    endtask

    task automatic load_string(input string s);
        for (int i = 0; i < s.len(); i++)
            write_buf(i, int'(s[i]));
    endtask

    task automatic run_string(input int len, input int x, input int y, input bit sz,
                              input bit junk, input bit spurious, input string tag);
        int cyc, last_done, pend, nf, due, prev_idx;
        bit in_wait, seen_done;
        glyph_t g, hold;
        model_string(len, x, y, sz);
        got_q.delete();
        got_ovf = 0;
        str_len = 5'(len); str_x = 9'(x); str_y = 9'(y); size_sel = sz;
        str_req = 1'b1;
        @(posedge sys_clk); #1;
        str_req = 1'b0;
        cyc = 1; last_done = -1; pend = 0; nf = 0; prev_idx = -1;
        in_wait = 0; seen_done = 0; hold = '{0, 0, 0, 0};
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_cycle1 got=%0b want=1", tag, busy);
        end
        while (cyc < 600) begin
            show_char_done = 1'b0;
            buf_we = 1'b0;
            str_req = 1'b0;
            if (show_char_flag) begin
                g.a = int'(ascii_num); g.x = int'(start_x); g.y = int'(start_y); g.idx = 0;
                got_q.push_back(g);
                if (nf < exp_q.size() && exp_q[nf].idx == prev_idx + 1) begin
                    due = (nf == 0) ? 3 : last_done + 3;
                    checks++;
                    if (cyc != due) begin
                        failures++;
                        $display("FAIL %s flag_timing glyph=%0d got=%0d want=%0d", tag, nf, cyc, due);
                    end
                end
                if (nf < exp_q.size())
                    prev_idx = exp_q[nf].idx;
                nf++;
                hold = g;
                in_wait = 1;
                pend = 1 + int'($urandom_range(0, 3));
                if (spurious)
                    show_char_done = 1'b1;
            end else if (in_wait) begin
                checks++;
                if (show_char_flag !== 1'b0 || int'(ascii_num) != hold.a || int'(start_x) != hold.x ||
                    int'(start_y) != hold.y || en_size !== sz) begin
                    failures++;
                    $display("FAIL %s wait_stable got=%0h/%0d/%0d/%0b want=%0h/%0d/%0d/%0b",
                             tag, ascii_num, start_x, start_y, en_size, hold.a, hold.x, hold.y, sz);
                end
                pend--;
                if (pend == 0) begin
                    show_char_done = 1'b1;
                    last_done = cyc;
                    in_wait = 0;
                end
            end
            if (str_done) begin
                seen_done = 1;
                got_ovf = overflow;
                if (len == 0) begin
                    checks++;
                    if (cyc != 2) begin
                        failures++;
                        $display("FAIL %s done_timing_len0 got=%0d want=2", tag, cyc);
                    end
                end else if (!exp_ovf && exp_q.size() > 0 && exp_q[exp_q.size()-1].idx == len - 1) begin
                    checks++;
                    if (cyc != last_done + 2) begin
                        failures++;
                        $display("FAIL %s done_timing got=%0d want=%0d", tag, cyc, last_done + 2);
                    end
                end
                break;
            end
            if (junk) begin
                buf_we = 1'b1;
                buf_addr = 4'($urandom_range(0, 15));
                buf_data = 7'($urandom_range(0, 127));
                str_req = 1'($urandom_range(0, 1));
                str_len = 5'($urandom_range(0, 16));
                str_x = 9'($urandom_range(0, 239));
            end
            @(posedge sys_clk); #1;
            cyc++;
        end
        show_char_done = 1'b0; buf_we = 1'b0; str_req = 1'b0;
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL %s timeout got=no_str_done want=str_done", tag);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (busy !== 1'b0 || str_done !== 1'b0) begin
            failures++;
            $display("FAIL %s post_idle got=busy%0b/done%0b want=0/0", tag, busy, str_done);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s glyph_count got=%0d want=%0d", tag, got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k].a != exp_q[k].a || got_q[k].x != exp_q[k].x || got_q[k].y != exp_q[k].y) begin
                failures++;
                $display("FAIL %s glyph%0d got=%0h@(%0d,%0d) want=%0h@(%0d,%0d)", tag, k,
                         got_q[k].a, got_q[k].x, got_q[k].y, exp_q[k].a, exp_q[k].x, exp_q[k].y);
            end
        end
        checks++;
        if (got_ovf !== exp_ovf) begin
            failures++;
            $display("FAIL %s overflow got=%0b want=%0b", tag, got_ovf, exp_ovf);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({show_char_flag, ascii_num, start_x, start_y, en_size, busy, str_done, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0b/%0h/%0d/%0d/%0b/%0b/%0b/%0b want=all0",
                     show_char_flag, ascii_num, start_x, start_y, en_size, busy, str_done, overflow);
        end
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_basic_ab();
        load_string("AB");
        run_string(2, 0, 0, 1'b0, 1'b0, 1'b0, "basic_ab");
        checks++;
        if (got_q.size() != 2 || got_q[0].a != 'h21 || got_q[1].a != 'h22 || got_q[1].x != 6) begin
            failures++;
            $display("FAIL basic_ab_literal got=n%0d want=n2 A/B x0,6", got_q.size());
        end
    endtask

    task automatic test_wrap();
        load_string("0123456789abcdef");
        run_string(16, 120, 0, 1'b1, 1'b0, 1'b0, "wrap");
        checks++;
        if (got_q.size() != 16 || got_q[14].x != 232 || got_q[15].x != 120 || got_q[15].y != 16) begin
            failures++;
            $display("FAIL wrap_literal got=n%0d want=n16 x232 then (120,16)", got_q.size());
        end
    endtask

    task automatic test_newline();
        load_string("A\nB");
        run_string(3, 10, 20, 1'b0, 1'b0, 1'b1, "newline");
        checks++;
        if (got_q.size() != 2 || got_q[1].x != 10 || got_q[1].y != 32) begin
            failures++;
            $display("FAIL newline_literal got=n%0d want=n2 B@(10,32)", got_q.size());
        end
    endtask

    task automatic test_overflow();
        load_string("AAAAAAAAAAAAAAAA");
        run_string(16, 120, 300, 1'b1, 1'b0, 1'b0, "overflow");
        checks++;
        if (got_ovf !== 1'b1 || got_q.size() != 15) begin
            failures++;
            $display("FAIL overflow_literal got=ovf%0b n%0d want=ovf1 n15", got_ovf, got_q.size());
        end
        foreach (got_q[k]) begin
            checks++;
            if (got_q[k].y > 304) begin
                failures++;
                $display("FAIL overflow_y glyph%0d got=%0d want<=304", k, got_q[k].y);
            end
        end
    endtask

    task automatic test_len0();
        run_string(0, 5, 5, 1'b0, 1'b0, 1'b0, "len0");
    endtask

    task automatic test_busy_ignore();
        load_string("Hello, LCD! 0123");
        run_string(16, 0, 100, 1'b0, 1'b1, 1'b0, "busy_junk");
        run_string(16, 0, 100, 1'b0, 1'b0, 1'b0, "busy_rerun");
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_string("XYZ");
        str_len = 5'd3; str_x = 9'd40; str_y = 9'd40; size_sel = 1'b1;
        str_req = 1'b1;
        @(posedge sys_clk); #1;
        str_req = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (show_char_flag) seen = 1;
            else begin @(posedge sys_clk); #1; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reset_mid_flag got=no_flag want=flag");
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, show_char_flag, str_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_async got=%0b%0b%0b want=000", busy, show_char_flag, str_done);
        end
        @(posedge sys_clk); #1;
        checks++;
        if ({busy, show_char_flag, str_done, overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_edge got=%0b%0b%0b%0b want=0000", busy, show_char_flag, str_done, overflow);
        end
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        run_string(3, 40, 40, 1'b1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) begin
                r = int'($urandom_range(0, 9));
                write_buf(i, (r == 0) ? 10 : (r == 1) ? int'($urandom_range(0, 127)) : int'($urandom_range(32, 126)));
            end
            run_string(int'($urandom_range(1, 16)), int'($urandom_range(0, 239)),
                       int'($urandom_range(0, 319)), 1'($urandom_range(0, 1)),
                       1'b0, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_ab();
        test_wrap();
        test_newline();
        test_overflow();
        test_len0();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
